// File: rtl/rs_scheduler_pkg.sv
// Shared reservation-station constants. RS storage and the scheduler both
// size themselves from these so the entry count is defined in one place.
package rs_scheduler_pkg;

    localparam int RS_SIZE  = 16;
    localparam int RS_IDX_W = $clog2(RS_SIZE);

endpackage : rs_scheduler_pkg

// File: rtl/rs_scheduler_rr_picker.sv
// Round-robin picker: returns the first set request bit at or after the
// pointer, scanning upward and wrapping. Purely combinational so a second
// issue port can instantiate another copy with its own pointer.
module rs_rr_picker #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [W-1:0]   w_off;

    // Rotate the request vector so the pointer lands on bit 0, then take the
    // lowest set bit; the offset added back to the pointer wraps naturally.
    always_comb begin
        w_dbl = {i_req, i_req} >> i_ptr;
        w_rot = w_dbl[N-1:0];
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = W'(i);
            end
        end
        o_found = |w_rot;
        o_idx   = i_ptr + w_off;
    end

endmodule : rs_rr_picker

// File: rtl/rs_scheduler.sv
// Reservation-station allocation and issue controller. Tracks entry
// occupancy, offers the lowest free slot to the dispatcher and issues one
// operand-ready entry per cycle to the ALU in round-robin order.
module rs_scheduler
    import rs_scheduler_pkg::*;
#(
    parameter int RS_SIZE  = rs_scheduler_pkg::RS_SIZE,
    parameter int RS_IDX_W = rs_scheduler_pkg::RS_IDX_W
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                clear_in,
    input  logic                alloc_req_in,
    output logic                alloc_ok_out,
    output logic [RS_IDX_W-1:0] alloc_idx_out,
    output logic                full_out,
    input  logic [RS_SIZE-1:0]  ready_vec_in,
    input  logic                alu_ready_in,
    output logic                issue_valid_out,
    output logic [RS_IDX_W-1:0] issue_idx_out,
    output logic [RS_IDX_W:0]   count_out
);

    logic [RS_SIZE-1:0]  r_busy;
    logic [RS_IDX_W-1:0] r_rr_ptr;
    logic                r_issue_valid;
    logic [RS_IDX_W-1:0] r_issue_idx;
    logic [RS_IDX_W:0]   r_count;
    logic                r_full;

    logic [RS_SIZE-1:0]  w_cand;
    logic                w_found;
    logic [RS_IDX_W-1:0] w_pick_idx;
    logic                w_do_alloc;
    logic                w_do_issue;
    logic [RS_SIZE-1:0]  w_busy_next;
    logic [RS_IDX_W:0]   w_count_next;

    // Lowest-index free slot; depends only on registered busy so the
    // dispatcher sees no input-to-output path.
    always_comb begin
        alloc_ok_out  = ~(&r_busy);
        alloc_idx_out = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                alloc_idx_out = RS_IDX_W'(i);
            end
        end
    end

    // Ready bits of empty entries are ignored.
    assign w_cand = r_busy & ready_vec_in;

    rs_rr_picker #(
        .N (RS_SIZE),
        .W (RS_IDX_W)
    ) u_picker (
        .i_req   (w_cand),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick_idx)
    );

    assign w_do_alloc = alloc_req_in & alloc_ok_out;
    assign w_do_issue = alu_ready_in & w_found;

    // Next occupancy and count; alloc never targets a busy entry, so the
    // set and clear can never collide on the same bit.
    always_comb begin
        w_busy_next = r_busy;
        if (w_do_alloc) begin
            w_busy_next[alloc_idx_out] = 1'b1;
        end
        if (w_do_issue) begin
            w_busy_next[w_pick_idx] = 1'b0;
        end
        w_count_next = r_count + (RS_IDX_W + 1)'(w_do_alloc)
                               - (RS_IDX_W + 1)'(w_do_issue);
    end

    // State update: clear beats alloc/issue; rdy_in low freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_busy        <= '0;
            r_rr_ptr      <= '0;
            r_issue_valid <= 1'b0;
            r_issue_idx   <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
        end else if (rdy_in) begin
            if (clear_in) begin
                r_busy        <= '0;
                r_rr_ptr      <= '0;
                r_issue_valid <= 1'b0;
                r_count       <= '0;
                r_full        <= 1'b0;
            end else begin
                r_busy        <= w_busy_next;
                r_count       <= w_count_next;
                r_full        <= (w_count_next == (RS_IDX_W + 1)'(RS_SIZE));
                r_issue_valid <= w_do_issue;
                if (w_do_issue) begin
                    r_issue_idx <= w_pick_idx;
                    r_rr_ptr    <= w_pick_idx + RS_IDX_W'(1);
                end
            end
        end
    end

    assign issue_valid_out = r_issue_valid;
    assign issue_idx_out   = r_issue_idx;
    assign count_out       = r_count;
    assign full_out        = r_full;

endmodule : rs_scheduler

// File: tb/tb_rs_scheduler.sv
// Directed bench for rs_scheduler: fill, drain, round-robin wrap,
// simultaneous alloc/issue, clear priority, rdy freeze and async reset.
module tb_rs_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        alloc_req_in;
    logic        alloc_ok_out;
    logic [3:0]  alloc_idx_out;
    logic        full_out;
    logic [15:0] ready_vec_in;
    logic        alu_ready_in;
    logic        issue_valid_out;
    logic [3:0]  issue_idx_out;
    logic [4:0]  count_out;

    int n_vec = 0;
    int n_err = 0;

    rs_scheduler dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .clear_in        (clear_in),
        .alloc_req_in    (alloc_req_in),
        .alloc_ok_out    (alloc_ok_out),
        .alloc_idx_out   (alloc_idx_out),
        .full_out        (full_out),
        .ready_vec_in    (ready_vec_in),
        .alu_ready_in    (alu_ready_in),
        .issue_valid_out (issue_valid_out),
        .issue_idx_out   (issue_idx_out),
        .count_out       (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0h expected=%0h", n_vec, tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; alloc_req_in = 1'b0;
        ready_vec_in = '0; alu_ready_in = 1'b0;
        #12;
        check("rst_count", count_out, 0);
        check("rst_full", full_out, 0);
        check("rst_valid", issue_valid_out, 0);
        check("rst_idx", issue_idx_out, 0);
        check("rst_alloc_ok", alloc_ok_out, 1);
        check("rst_alloc_idx", alloc_idx_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        tick();

        // Fill all 16 entries back to back.
        alloc_req_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("fill_alloc_idx", alloc_idx_out, i);
            check("fill_alloc_ok", alloc_ok_out, 1);
            tick();
        end
        alloc_req_in = 1'b0;
        #1;
        check("full_alloc_ok", alloc_ok_out, 0);
        check("full_flag", full_out, 1);
        check("full_count", count_out, 16);

        // Drain everything in index order.
        ready_vec_in = 16'hFFFF; alu_ready_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("drain_valid", issue_valid_out, 1);
            check("drain_idx", issue_idx_out, i);
            check("drain_count", count_out, 15 - i);
        end
        tick();
        check("drain_end_valid", issue_valid_out, 0);
        check("drain_end_count", count_out, 0);
        check("drain_end_full", full_out, 0);
        alu_ready_in = 1'b0; ready_vec_in = '0;

        // Refill, then issue 13 to put the pointer at 14.
        alloc_req_in = 1'b1;
        repeat (16) tick();
        alloc_req_in = 1'b0;
        ready_vec_in = 16'h2000; alu_ready_in = 1'b1;
        tick();
        check("rr_pre_idx", issue_idx_out, 13);
        ready_vec_in = 16'h8008;
        tick();
        check("rr_wrap_a", issue_idx_out, 15);
        tick();
        check("rr_wrap_b", issue_idx_out, 3);
        ready_vec_in = 16'h0024;  // entries 2 and 5; pointer 4 must choose 5
        tick();
        check("rr_ptr4", issue_idx_out, 5);
        alu_ready_in = 1'b0; ready_vec_in = '0;
        tick();
        check("rr_count", count_out, 12);
        check("rr_alloc_idx", alloc_idx_out, 3);

        // Refill the four holes (3, 5, 13, 15).
        alloc_req_in = 1'b1;
        #1; check("hole_a", alloc_idx_out, 3);  tick();
        check("hole_b", alloc_idx_out, 5);  tick();
        check("hole_c", alloc_idx_out, 13); tick();
        check("hole_d", alloc_idx_out, 15); tick();
        check("refill_full", full_out, 1);
        check("refill_count", count_out, 16);

        // Alloc request while full is ignored; issue 5 frees that slot.
        ready_vec_in = 16'h0020; alu_ready_in = 1'b1;
        tick();
        check("free5_idx", issue_idx_out, 5);
        check("free5_count", count_out, 15);
        check("free5_full", full_out, 0);
        check("free5_ok", alloc_ok_out, 1);
        check("free5_alloc_idx", alloc_idx_out, 5);
        alu_ready_in = 1'b0;
        tick();
        check("realloc5_count", count_out, 16);
        check("realloc5_full", full_out, 1);

        // Issue 6, then alloc 6 while issuing 7: count unchanged.
        alloc_req_in = 1'b0; ready_vec_in = 16'h0040; alu_ready_in = 1'b1;
        tick();
        check("iss6_idx", issue_idx_out, 6);
        check("iss6_count", count_out, 15);
        alloc_req_in = 1'b1; ready_vec_in = 16'h0080;
        tick();
        check("sim_idx", issue_idx_out, 7);
        check("sim_count", count_out, 15);
        check("sim_alloc_idx", alloc_idx_out, 7);

        // Clear wins over alloc and issue.
        ready_vec_in = 16'hFFFF; clear_in = 1'b1;
        tick();
        clear_in = 1'b0; alloc_req_in = 1'b0;
        check("clr_count", count_out, 0);
        check("clr_full", full_out, 0);
        check("clr_valid", issue_valid_out, 0);
        check("clr_idx_hold", issue_idx_out, 7);
        check("clr_alloc_idx", alloc_idx_out, 0);
        check("clr_alloc_ok", alloc_ok_out, 1);
        tick();
        check("clr_no_cand", issue_valid_out, 0);

        // Allocate 0..9, issue 7 (pointer 0 after clear, only 7 and 9 ready).
        alu_ready_in = 1'b0; ready_vec_in = '0; alloc_req_in = 1'b1;
        repeat (10) tick();
        alloc_req_in = 1'b0;
        ready_vec_in = 16'h0280; alu_ready_in = 1'b1;
        tick();
        check("frz_pre_idx", issue_idx_out, 7);
        check("frz_pre_count", count_out, 9);

        // Freeze for three edges with active requests.
        rdy_in = 1'b0; alloc_req_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_valid", issue_valid_out, 1);
            check("frz_idx", issue_idx_out, 7);
            check("frz_count", count_out, 9);
        end
        check("frz_alloc_idx", alloc_idx_out, 7);
        rdy_in = 1'b1; alloc_req_in = 1'b0;
        tick();
        check("resume_idx", issue_idx_out, 9);
        check("resume_count", count_out, 8);

        // Asynchronous reset between edges.
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_count", count_out, 0);
        check("arst_valid", issue_valid_out, 0);
        check("arst_idx", issue_idx_out, 0);
        check("arst_alloc_idx", alloc_idx_out, 0);
        rst_in = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rs_scheduler

// File: doc/rs_scheduler.md
# rs_scheduler

Allocation and issue controller for the reservation station. It owns the per-entry occupancy vector, hands free slot indices to the dispatcher, and selects one operand-ready entry per cycle for the single ALU using a round-robin pointer. It sits between dispatcher, reservation-station storage and ALU, and it flushes all entries on a ROB clear (branch mispredict).

## Interface
Parameters:
- RS_SIZE, default 16: number of reservation-station entries (power of two).
- RS_IDX_W, default 4: log2(RS_SIZE).

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global clock enable; low freezes every register.
- clear_in  input  1  flush (mispredict); frees every entry.
- alloc_req_in  input  1  dispatcher writes a new instruction this cycle.
- alloc_ok_out  output  1  combinational; a free entry exists.
- alloc_idx_out  output  RS_IDX_W  combinational; lowest-index free entry (0 when none).
- full_out  output  1  registered; no free entry after this edge's updates.
- ready_vec_in  input  RS_SIZE  per-entry "Q1 and Q2 resolved" from RS storage.
- alu_ready_in  input  1  ALU accepts an instruction at this edge.
- issue_valid_out  output  1  registered; issue_idx_out is valid this cycle.
- issue_idx_out  output  RS_IDX_W  registered; entry the RS drives to the ALU.
- count_out  output  RS_IDX_W+1  registered; occupied entries.

## Operation
- State: busy[RS_SIZE], rr_ptr[RS_IDX_W], issue_valid_out, issue_idx_out, count_out, full_out.
- Reset: busy all 0, rr_ptr 0, issue_valid_out 0, issue_idx_out 0, count_out 0, full_out 0.
- Allocation: alloc_idx_out is the priority encode of ~busy using the current-cycle busy vector. At an edge with alloc_req_in and alloc_ok_out high, busy[alloc_idx_out] is set to 1. An alloc_req_in with alloc_ok_out low is a dispatcher error and is ignored (no state change).
- Candidates: busy & ready_vec_in. Bits of ready_vec_in for non-busy entries are ignored.
- Selection: the first candidate at or after rr_ptr, scanning upward and wrapping modulo RS_SIZE.
- Issue at an edge with alu_ready_in high and at least one candidate:
  - issue_valid_out is set to 1 and issue_idx_out to the selected index.
  - busy[idx] is set to 0.
  - rr_ptr is set to (idx+1) mod RS_SIZE.
- Otherwise issue_valid_out is set to 0, and issue_idx_out and rr_ptr hold.
- The entry is freed at the same edge it is issued. The RS reads the issued payload combinationally during the issue_valid_out cycle. Because stores happen only at the next edge, a same-cycle re-allocation of that index is legal.
- count_out update: count + (alloc accepted) − (issue granted). Simultaneous alloc and issue leaves count unchanged. These never target the same index, since alloc only picks entries that are not busy.
- full_out is set to (next count == RS_SIZE).
- clear_in has priority over alloc and issue in the same cycle:
  - busy is cleared to 0, count_out to 0, full_out to 0, issue_valid_out to 0, rr_ptr to 0.
  - issue_idx_out holds.
- rdy_in low: nothing changes. Outputs hold, including a high issue_valid_out; the ALU is frozen by the same rdy_in.
- Asynchronous reset mid-operation returns to reset values immediately, independent of clk_in and rdy_in.

## Timing
- Alloc → entry eligible: the entry is busy after edge N. With ready_vec_in high in cycle N+1, it can issue at edge N+1, so issue_valid_out is high in cycle N+1→N+2.
- Issue latency: one edge from a qualified candidate to issue_valid_out.
- Throughput: one issue per cycle while alu_ready_in stays high.
- A freed slot is visible on alloc_ok_out in the cycle after the issue edge.
- full_out lags combinational alloc_ok_out by up to one cycle. The dispatcher stalls on alloc_ok_out; full_out is the registered stall hint for the fetch path.
- Combinational paths: busy to alloc_ok_out/alloc_idx_out only. No input-to-output combinational path.

## Structure
- Shared constants header: RS_SIZE and the RS index width, used by both RS storage and this block.
- One natural sub-module: rs_rr_picker. It is combinational; it takes a request vector and pointer and returns a found flag and index, implemented as a double-width vector scan or a rotate + priority encode. It is reused for any future second issue port.
- The free-slot priority encoder stays inline.

## Test plan
- Reset, then 16 back-to-back allocs with ready_vec_in=0 → alloc_idx_out = 0,1,…,15. alloc_ok_out drops in the cycle after the 16th alloc. full_out=1, count_out=16.
- All entries busy, ready_vec_in=16'hFFFF, alu_ready_in=1 → issue_idx_out sequence 0,1,2,…,15, one per cycle, then issue_valid_out=0 and count_out=0.
- Round-robin wrap: rr_ptr=14, candidates {3,15} → issue 15, then 3, then rr_ptr=4.
- Simultaneous alloc and issue with entries 0–15 full, issuing 5 → alloc_ok_out=1 with alloc_idx_out=5 next cycle. Allocating it leaves count_out=16.
- clear_in asserted with alloc_req_in and alu_ready_in both high → next cycle busy=0, count_out=0, issue_valid_out=0, alloc_idx_out=0.
- rdy_in low for 3 cycles while issue_valid_out=1, idx=7 → outputs unchanged. Resume → the next candidate after 7 is issued. Async rst_in pulse between edges → outputs reset immediately.
